// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants, used by this encoder and by the control decode unit.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_LW   = 3'd1;
    localparam logic [2:0] KIND_SW   = 3'd2;
    localparam logic [2:0] KIND_BEQ  = 3'd3;
    localparam logic [2:0] KIND_ADDI = 3'd4;

    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_ADDI = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // A 13-bit immediate fits the 12-bit I/S field only when its top two bits agree.
    function automatic logic imm_fits12(input logic [12:0] imm);
        return imm[12] == imm[11];
    endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational field packer: symbolic RV32I fields in, machine word plus illegal flag out.
module rv_instr_pack
    import rv_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [12:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_R: begin
                word_o    = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
                illegal_o = (funct7_i != F7_BASE) && (funct7_i != F7_ALT);
            end
            KIND_LW: begin
                word_o    = {imm_i[11:0], rs1_i, F3_LW, rd_i, OP_LOAD};
                illegal_o = !imm_fits12(imm_i);
            end
            KIND_ADDI: begin
                word_o    = {imm_i[11:0], rs1_i, F3_ADDI, rd_i, OP_IMM};
                illegal_o = !imm_fits12(imm_i);
            end
            KIND_SW: begin
                word_o    = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OP_STORE};
                illegal_o = !imm_fits12(imm_i);
            end
            KIND_BEQ: begin
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                             imm_i[4:1], imm_i[11], OP_BRANCH};
                // Branch targets are halfword aligned; bit 0 has no slot in the word.
                illegal_o = imm_i[0];
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Streaming RV32I encoder: accepts symbolic requests, emits address-tagged words through
// a one-entry registered output stage, dropping and counting illegal requests.
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_word,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky
);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              err_sticky_q, err_sticky_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        accept, load, drop, drain;

    rv_instr_pack u_pack (
        .kind_i    (in_kind),
        .rd_i      (in_rd),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .funct3_i  (in_funct3),
        .funct7_i  (in_funct7),
        .imm_i     (in_imm),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

    // Handshakes: a beat transfers on a cycle where valid && ready are both high.
    // in_ready never looks at in_valid, and out_valid only changes on the clock, so
    // the stage refills in the same cycle it drains without any valid-to-valid path.
    assign in_ready = !clr && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && !pack_illegal;
    assign drop     = accept && pack_illegal;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_addr_d   = out_addr_q;
        next_addr_d  = next_addr_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (clr) begin
            out_valid_d  = 1'b0;
            out_word_d   = '0;
            out_addr_d   = '0;
            next_addr_d  = '0;
            word_count_d = '0;
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else begin
            if (drain) begin
                out_valid_d = 1'b0;
                if (word_count_q != '1) word_count_d = word_count_q + 1'b1;
            end
            // A load in the drain cycle overrides the clear of out_valid above.
            if (load) begin
                out_valid_d = 1'b1;
                out_word_d  = pack_word;
                out_addr_d  = next_addr_q;
                next_addr_d = next_addr_q + 1'b1;
            end
            if (drop) begin
                if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                err_sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_addr_q   <= '0;
            next_addr_q  <= '0;
            word_count_q <= '0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_addr_q   <= out_addr_d;
            next_addr_q  <= next_addr_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign out_addr   = out_addr_q;
    assign word_count = word_count_q;
    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
Streaming RV32I instruction encoder. It is the inverse of the opcode/control decode path: it takes symbolic instruction fields and emits 32-bit machine words tagged with sequential instruction-memory word addresses. It is used by the program loader and testbenches to fill IMEM. Input and output are valid/ready streams with a one-entry registered output stage. Illegal requests are dropped and flagged.

Parameters:
ADDR_W, 8, width of the IMEM word-address counter; the counter wraps at 2**ADDR_W.
CNT_W, 16, width of the emitted-word and error counters; both saturate at all-ones.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr  in  1  synchronous pulse; clears address, counters and error state
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_kind  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI; 5-7 illegal
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  used for R only
in_funct7  in  7  used for R only; must be 0x00 or 0x20
in_imm  in  13  signed immediate
out_valid  out  1  word valid
out_ready  in  1  downstream accept
out_addr  out  ADDR_W  IMEM word address of out_word
out_word  out  32  encoded instruction
word_count  out  CNT_W  number of words accepted downstream
err_count  out  CNT_W  number of dropped requests
err_sticky  out  1  set on the first dropped request; cleared only by rst or clr

Behaviour:
- Reset: out_valid=0, out_addr=0, out_word=0, word_count=0, err_count=0, err_sticky=0, internal next-address=0.
- in_ready = !clr && (!out_valid || out_ready). The stage is full-throughput; there is no combinational path from in_valid to out_valid.
- On accept of a legal request: out_word and out_addr are loaded from the encoder and the next-address register, out_valid=1 on the next cycle, and next-address increments by 1 mod 2**ADDR_W. Latency is 1 cycle.
- out_valid && out_ready with no new legal accept: out_valid=0 next cycle. word_count increments on every out_valid && out_ready.
- Output is held stable while out_valid && !out_ready.
- Encoding by in_kind:
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}.
  - LW: {imm[11:0], rs1, 010, rd, 0000011}.
  - ADDI: {imm[11:0], rs1, 000, rd, 0010011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
- Illegal request, checked at accept time:
  - in_kind >= 5.
  - R with funct7 not 0x00 or 0x20.
  - LW/SW/ADDI with in_imm outside -2048..2047 (imm[12] != imm[11]).
  - BEQ with imm[0]=1.
  - Effect: the request is consumed (handshake completes), no output is loaded, next-address is unchanged, err_count increments, err_sticky=1. An existing out_valid word may still drain in the same cycle.
- Unused fields (e.g. rd for SW/BEQ, rs2 for I-type) are ignored and never cause errors.
- Address wrap: after word 2**ADDR_W-1 the next address is 0, with no flag.
- Counters saturate at 2**CNT_W-1.
- clr (priority below rst, above everything else): next cycle out_valid=0, next-address=0, word_count=0, err_count=0, err_sticky=0. Any pending output word is discarded, and in_ready=0 during the clr cycle.
- rst mid-stream: same as clr, and all outputs return to reset values.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_IMM=0010011;
  - the KIND_* encodings 0-4;
  - F3_LW=010, F3_SW=010, F3_BEQ=000, F3_ADDI=000; and F7_BASE=0x00, F7_ALT=0x20.
- This package is shared with the control decode unit.
- One combinational sub-module, rv_instr_pack: fields in, {word[31:0], illegal} out. The top level holds the handshake, registers and counters.

Test Plan:
- ADDI kind=4 rd=1 rs1=0 imm=5 after reset -> out_word=0x00500093, out_addr=0, out_valid 1 cycle after accept.
- R rd=3 rs1=1 rs2=2 f3=0 f7=0x00, then f7=0x20, with out_ready=1 -> 0x002081B3 @0 then 0x402081B3 @1; word_count=2.
- LW rd=5 rs1=2 imm=8 then SW rs2=5 rs1=2 imm=12, with out_ready=0 for 3 cycles -> 0x00812283 held stable and in_ready=0; after release 0x00512623 @1.
- BEQ rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; then BEQ imm=3 and ADDI imm=2048 -> both dropped, err_count=2, err_sticky=1, next address unchanged.
- ADDR_W=2: 5 legal words -> out_addr sequence 0,1,2,3,0.
- Pending word with out_ready=0, then clr pulse -> out_valid=0, err_sticky=0, counters 0; next legal word at out_addr=0.
